alu6502_serial_bcd: RTL and testbench
=====================================

// Module: alu6502_serial_bcd
// PURPOSE
//  Parametrised, digit-serial successor to the 8-bit 6502 ALU. Computes add/sub/shift/logic on WIDTH-bit
//  operands, DPC BCD digits (nibbles) per clock, LSB digit first, with true decimal add AND subtract.
//  Valid/ready on input and output; sits between CPU microsequencer and wide (16/32-bit) datapaths.
// PARAMETERS
//  WIDTH  8  operand width; multiple of 4, 8..32
//  DPC    1  digits processed per clock; must divide WIDTH/4. NSTEP = WIDTH/(4*DPC)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      op/a/b/ci/bcd valid
//  in_ready   out  1      block accepts operation this cycle
//  op         in   4      0011 A+B, 0111 A-B, 1011 A+A, 0001 ROR, 1100 OR, 1101 AND, 1110 XOR, 1111 A
//  a, b       in   WIDTH  operands
//  ci         in   1      carry in (sub: 1 = no borrow)
//  bcd        in   1      decimal mode; affects 0011/0111/1011 only
//  out_valid  out  1      result and flags valid
//  out_ready  in   1      consumer takes result
//  result     out  WIDTH  result
//  co, v, z, n, hc  out 1 carry, overflow, zero, negative, digit-0 half carry
// BEHAVIOUR
//  Reset: state IDLE; result, co, v, z, n, hc, out_valid = 0; in_ready = 1. Reset mid-RUN aborts; no output.
//  FSM IDLE -> RUN on in_valid&in_ready (operands, ci, bcd, op captured; step=0).
//   RUN: each edge processes DPC digits from LSB, carry chained between digits and cycles; step++.
//   RUN -> DONE on edge completing step NSTEP-1; out_valid=1 from then, i.e. NSTEP cycles after accept.
//   DONE: result/flags held stable while out_ready=0. DONE&out_ready: -> IDLE, or -> RUN if in_valid
//   (new op captured same edge; back-to-back throughput NSTEP+1 cycles).
//  in_ready = (state==IDLE) | (state==DONE & out_ready), combinational from state/out_ready.
//  Outputs are registered; hold last value outside DONE until next completion overwrites them.
//  Digit arithmetic (carry c into digit, 5-bit d):
//   add: d = a_d + b_d + c; bcd & d>9 -> digit=(d+6)[3:0], c'=1; else digit=d[3:0], c'=d[4].
//   sub: d = a_d + ~b_d + c; c'=d[4]; bcd & !d[4] -> digit=(d-6)[3:0]; else digit=d[3:0].
//   A+A: add with b=a (decimal doubling when bcd). ci used as c into digit 0 for add/sub/A+A.
//   Non-BCD digit inputs in bcd mode: result is formula above mod 16; no error flag.
//  ROR: result={ci,a[W-1:1]}, co=a[0]; bcd ignored. OR/AND/XOR/A: co=ci, v=0, hc=0.
//  Other op codes: behave as 1111 (pass A).
//  Flags: n=result[W-1]; z=(result==0); co=carry out of top digit (ROR/logic as above);
//   hc=carry out of digit 0 (post-adjust) for add/sub/A+A, else 0;
//   v=signed overflow of binary sum: (a[W-1]==b'[W-1]) & (s[W-1]!=a[W-1]), b'=b/~b/a, s=pre-adjust sum.
//  DPC>1: decimal adjust cascades through all digits of a cycle combinationally.
// TESTING
//  W=8,DPC=1: add 0x45+0x38 bcd=1 ci=0 -> 0x83, co=0, hc=1; out_valid 2 cycles after accept.
//  W=8 sub bcd=1 ci=1: 0x32-0x15 -> 0x17 co=1; 0x00-0x01 -> 0x99 co=0, n=1.
//  W=8 add bcd=0: 0x7F+0x01 ci=0 -> 0x80, v=1, n=1, co=0, z=0; ROR 0x81 ci=1 -> 0xC0, co=1.
//  W=16,DPC=2: add 0x9999+0x0001 bcd=1 -> 0x0000, co=1, z=1, out_valid 2 cycles after accept.
//  out_ready=0 5 cycles: result/flags stable, in_ready=0; then out_ready=1&in_valid=1 -> accepted same edge.
//  rst_n low during RUN -> out_valid=0, in_ready=1, all outputs 0; next op completes normally.

Source files
------------

// File: rtl/alu6502_serial_bcd.sv
// Digit-serial 6502-style ALU: add/sub/shift/logic on WIDTH-bit operands, DPC nibbles per clock,
// LSB digit first, with decimal add and subtract.
module alu6502_serial_bcd #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DPC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             bcd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             co,
  output logic             v,
  output logic             z,
  output logic             n,
  output logic             hc
);

  localparam int unsigned NSTEP = WIDTH / (4 * DPC);
  localparam int unsigned SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int unsigned DW    = 4 * DPC;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
  typedef enum logic [2:0] {KAdd, KSub, KRor, KOr, KAnd, KXor, KPass} kind_e;

  state_e state_q, state_d;
  kind_e  kind_q, kind_in;

  // a_q carries ci above its MSB so ROR can pull the bit in from the top.
  logic [WIDTH:0]   a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             bcd_q;
  logic             carry_q;
  logic             hc_q;
  logic [SW-1:0]    step_q;

  logic             accept;
  logic             last_step;
  logic             arith;
  logic [DW-1:0]    digits;
  logic             c_out;
  logic             hc_cur;
  logic             top_s;
  logic             top_a;
  logic             top_b;
  logic [WIDTH-1:0] res_next;

  assign accept    = in_valid & in_ready;
  assign last_step = (step_q == SW'(NSTEP - 1));
  assign arith     = (kind_q == KAdd) || (kind_q == KSub);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StRun;
      StRun:   if (last_step) state_d = StDone;
      StDone:  if (out_ready) state_d = in_valid ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    out_valid = (state_q == StDone);
  end

  always_comb begin
    case (op)
      4'b0011, 4'b1011: kind_in = KAdd;
      4'b0111:          kind_in = KSub;
      4'b0001:          kind_in = KRor;
      4'b1100:          kind_in = KOr;
      4'b1101:          kind_in = KAnd;
      4'b1110:          kind_in = KXor;
      default:          kind_in = KPass;
    endcase
  end

  // Subtraction is stored as a + ~b so both arithmetic kinds share one adder per digit.
  always_comb begin : p_digits
    logic       c;
    logic [3:0] ad;
    logic [3:0] bd;
    logic [3:0] dig;
    logic [4:0] d;
    logic [4:0] d_hi;
    logic [4:0] d_lo;
    c      = carry_q;
    ad     = '0;
    bd     = '0;
    dig    = '0;
    d      = '0;
    d_hi   = '0;
    d_lo   = '0;
    digits = '0;
    hc_cur = 1'b0;
    top_s  = 1'b0;
    top_a  = 1'b0;
    top_b  = 1'b0;
    for (int k = 0; k < int'(DPC); k++) begin
      ad   = a_q[4*k +: 4];
      bd   = b_q[4*k +: 4];
      d    = {1'b0, ad} + {1'b0, bd} + {4'b0000, c};
      d_hi = d + 5'd6;
      d_lo = d - 5'd6;
      case (kind_q)
        KAdd: begin
          if (bcd_q && (d > 5'd9)) begin
            dig = d_hi[3:0];
            c   = 1'b1;
          end else begin
            dig = d[3:0];
            c   = d[4];
          end
        end
        KSub: begin
          dig = (bcd_q && !d[4]) ? d_lo[3:0] : d[3:0];
          c   = d[4];
        end
        KRor:    dig = a_q[4*k+1 +: 4];
        KOr:     dig = ad | bd;
        KAnd:    dig = ad & bd;
        KXor:    dig = ad ^ bd;
        default: dig = ad;
      endcase
      if (k == 0) hc_cur = c;
      if (k == int'(DPC) - 1) begin
        top_s = d[3];
        top_a = ad[3];
        top_b = bd[3];
      end
      digits[4*k +: 4] = dig;
    end
    c_out = c;
  end

  assign res_next = (res_q >> DW) | (WIDTH'(digits) << (WIDTH - DW));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      kind_q  <= KAdd;
      bcd_q   <= 1'b0;
      carry_q <= 1'b0;
      hc_q    <= 1'b0;
      step_q  <= '0;
      result  <= '0;
      co      <= 1'b0;
      v       <= 1'b0;
      z       <= 1'b0;
      n       <= 1'b0;
      hc      <= 1'b0;
    end else if (accept) begin
      a_q     <= {ci, a};
      b_q     <= (kind_in == KSub) ? ~b : ((op == 4'b1011) ? a : b);
      kind_q  <= kind_in;
      bcd_q   <= bcd;
      // Logic ops and ROR pass the chain carry straight through to co.
      carry_q <= (kind_in == KRor) ? a[0] : ci;
      step_q  <= '0;
    end else if (state_q == StRun) begin
      a_q     <= a_q >> DW;
      b_q     <= b_q >> DW;
      res_q   <= res_next;
      carry_q <= c_out;
      step_q  <= step_q + SW'(1);
      if (step_q == '0) hc_q <= hc_cur;
      if (last_step) begin
        result <= res_next;
        co     <= c_out;
        z      <= (res_next == '0);
        n      <= res_next[WIDTH-1];
        hc     <= arith & ((step_q == '0) ? hc_cur : hc_q);
        v      <= arith & (top_a == top_b) & (top_s != top_a);
      end
    end
  end

endmodule

// File: tb/tb_alu6502_serial_bcd.sv
// Bench for alu6502_serial_bcd: directed vector table, protocol corner cases and randomized ops
// against a decimal/integer reference model, on an 8-bit/1-digit and a 16-bit/2-digit instance.
module tb_alu6502_serial_bcd;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       iv8 = 0, or8 = 0, ci8 = 0, bcd8 = 0;
  logic [3:0] op8 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic       ir8, ov8, co8, v8, z8, n8, hc8;
  logic [7:0] res8;

  logic        iv16 = 0, or16 = 0, ci16 = 0, bcd16 = 0;
  logic [3:0]  op16 = 0;
  logic [15:0] a16 = 0, b16 = 0;
  logic        ir16, ov16, co16, v16, z16, n16, hc16;
  logic [15:0] res16;

  alu6502_serial_bcd #(.WIDTH(8), .DPC(1)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .op(op8), .a(a8), .b(b8),
    .ci(ci8), .bcd(bcd8), .out_valid(ov8), .out_ready(or8), .result(res8), .co(co8), .v(v8),
    .z(z8), .n(n8), .hc(hc8)
  );

  alu6502_serial_bcd #(.WIDTH(16), .DPC(2)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .op(op16), .a(a16), .b(b16),
    .ci(ci16), .bcd(bcd16), .out_valid(ov16), .out_ready(or16), .result(res16), .co(co16),
    .v(v16), .z(z16), .n(n16), .hc(hc16)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic longint dec(input longint x, input int nd);
    longint r = 0;
    longint m = 1;
    for (int i = 0; i < nd; i++) begin
      r += ((x >> (4 * i)) & 15) * m;
      m *= 10;
    end
    return r;
  endfunction

  function automatic longint tobcd(input longint x, input int nd);
    longint r = 0;
    longint t = x;
    for (int i = 0; i < nd; i++) begin
      r |= (t % 10) << (4 * i);
      t /= 10;
    end
    return r;
  endfunction

  // Returns {co, v, z, n, hc, result[31:0]}; decimal mode assumes valid BCD operands.
  function automatic logic [36:0] model(input int w, input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic ci, input logic bcd);
    longint mask, la, lb, lbp, s, r, p, q, da, db, t, bor, amsb;
    logic co, v, hc, z, n, top_s, cin_top;
    logic [31:0] res;
    mask = (longint'(1) << w) - 1;
    la = longint'(a) & mask;
    lb = longint'(b) & mask;
    bor = ci ? 0 : 1;
    co = ci; v = 0; hc = 0; res = a; r = 0; top_s = 0;
    case (op)
      4'b0011, 4'b0111, 4'b1011: begin
        if (op == 4'b0111) lbp = (~lb) & mask;
        else if (op == 4'b1011) lbp = la;
        else lbp = lb;
        if (!bcd) begin
          s = la + lbp + longint'(ci);
          r = s & mask;
          co = ((s >> w) & 1) != 0;
          hc = ((la & 15) + (lbp & 15) + longint'(ci)) > 15;
          top_s = ((r >> (w - 1)) & 1) != 0;
        end else begin
          p = 1;
          repeat (w / 4) p *= 10;
          q = p / 10;
          da = dec(la, w / 4);
          db = (op == 4'b1011) ? da : dec(lb, w / 4);
          if (op != 4'b0111) begin
            t = da + db + longint'(ci);
            co = t >= p;
            r = t % p;
            hc = (da % 10 + db % 10 + longint'(ci)) > 9;
            cin_top = (da % q + db % q + longint'(ci)) >= q;
          end else begin
            t = da - db - bor;
            co = t >= 0;
            r = (t + p) % p;
            hc = (da % 10 - db % 10 - bor) >= 0;
            cin_top = (da % q - db % q - bor) >= 0;
          end
          r = tobcd(r, w / 4);
          top_s = ((((la >> (w - 4)) & 15) + ((lbp >> (w - 4)) & 15) + longint'(cin_top)) & 8) != 0;
        end
        amsb = (la >> (w - 1)) & 1;
        v = (amsb == ((lbp >> (w - 1)) & 1)) && (longint'(top_s) != amsb);
        res = r[31:0];
      end
      4'b0001: begin
        s = (longint'(ci) << (w - 1)) | (la >> 1);
        res = s[31:0];
        co = a[0];
      end
      4'b1100: res = a | b;
      4'b1101: res = a & b;
      4'b1110: res = a ^ b;
      default: res = a;
    endcase
    res = res & mask[31:0];
    z = (res == 0);
    n = res[w-1];
    return {co, v, z, n, hc, res};
  endfunction

  task automatic wait_out8(input string name);
    int cyc = 0;
    while (!ov8 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "_latency"}, cyc, 2);
  endtask

  task automatic run8(input string name, input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic ci, input logic bcd,
                      input logic [7:0] er, input logic [4:0] ef);
    @(negedge clk);
    op8 = op; a8 = a; b8 = b; ci8 = ci; bcd8 = bcd; iv8 = 1;
    #1 check({name, "_in_ready"}, ir8, 1);
    @(posedge clk); #1 iv8 = 0;
    wait_out8(name);
    check({name, "_result"}, res8, er);
    check({name, "_flags"}, {co8, v8, z8, n8, hc8}, ef);
    @(negedge clk) or8 = 1;
    @(posedge clk); #1 or8 = 0;
  endtask

  task automatic run16(input string name, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic ci, input logic bcd,
                       input logic [15:0] er, input logic [4:0] ef);
    int cyc = 0;
    @(negedge clk);
    op16 = op; a16 = a; b16 = b; ci16 = ci; bcd16 = bcd; iv16 = 1;
    @(posedge clk); #1 iv16 = 0;
    while (!ov16 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "_latency"}, cyc, 2);
    check({name, "_result"}, res16, er);
    check({name, "_flags"}, {co16, v16, z16, n16, hc16}, ef);
    @(negedge clk) or16 = 1;
    @(posedge clk); #1 or16 = 0;
  endtask

  function automatic logic [31:0] rand_bcd(input int nd);
    logic [31:0] r = 0;
    for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       bcd;
    logic [7:0] res;
    logic [4:0] flags;  // {co, v, z, n, hc}
  } vec_t;

  vec_t vecs[14];
  logic [3:0] ops[10] = '{4'b0011, 4'b0111, 4'b1011, 4'b0001, 4'b1100, 4'b1101, 4'b1110,
                          4'b1111, 4'b0000, 4'b0101};

  initial begin
    logic [36:0] e;
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    logic        rci, rbcd;

    vecs[0]  = '{"add_bcd_45_38", 4'b0011, 8'h45, 8'h38, 1'b0, 1'b1, 8'h83, 5'b01011};
    vecs[1]  = '{"sub_bcd_32_15", 4'b0111, 8'h32, 8'h15, 1'b1, 1'b1, 8'h17, 5'b10000};
    vecs[2]  = '{"sub_bcd_00_01", 4'b0111, 8'h00, 8'h01, 1'b1, 1'b1, 8'h99, 5'b00010};
    vecs[3]  = '{"add_bin_7f_01", 4'b0011, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 5'b01011};
    vecs[4]  = '{"ror_81",        4'b0001, 8'h81, 8'h00, 1'b1, 1'b0, 8'hC0, 5'b10010};
    vecs[5]  = '{"or",            4'b1100, 8'h0F, 8'hF0, 1'b1, 1'b0, 8'hFF, 5'b10010};
    vecs[6]  = '{"and",           4'b1101, 8'h0F, 8'hF0, 1'b0, 1'b0, 8'h00, 5'b00100};
    vecs[7]  = '{"xor",           4'b1110, 8'h55, 8'hFF, 1'b0, 1'b1, 8'hAA, 5'b00010};
    vecs[8]  = '{"pass_a",        4'b1111, 8'h3C, 8'hFF, 1'b1, 1'b0, 8'h3C, 5'b10000};
    vecs[9]  = '{"other_op",      4'b0000, 8'h00, 8'h5A, 1'b0, 1'b0, 8'h00, 5'b00100};
    vecs[10] = '{"aa_bcd_45",     4'b1011, 8'h45, 8'h00, 1'b0, 1'b1, 8'h90, 5'b01011};
    vecs[11] = '{"aa_bin_80",     4'b1011, 8'h80, 8'h00, 1'b0, 1'b0, 8'h00, 5'b11100};
    vecs[12] = '{"add_bcd_99_01", 4'b0011, 8'h99, 8'h01, 1'b0, 1'b1, 8'h00, 5'b10101};
    vecs[13] = '{"sub_bin_00_01", 4'b0111, 8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 5'b00010};

    #23;
    check("rst_out_valid8", ov8, 0);
    check("rst_in_ready8", ir8, 1);
    check("rst_outputs8", {res8, co8, v8, z8, n8, hc8}, 0);
    check("rst_outputs16", {ov16, res16, co16, v16, z16, n16, hc16}, 0);
    @(negedge clk) rst_n = 1;

    foreach (vecs[i])
      run8(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].bcd,
           vecs[i].res, vecs[i].flags);

    // Stall with out_ready low, then release and accept the next op on the same edge.
    @(negedge clk);
    op8 = 4'b0011; a8 = 8'h45; b8 = 8'h38; ci8 = 0; bcd8 = 1; iv8 = 1;
    @(posedge clk); #1 iv8 = 0;
    wait_out8("hold_first");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_out_valid", ov8, 1);
      check("hold_in_ready", ir8, 0);
      check("hold_result", {res8, co8, v8, z8, n8, hc8}, {8'h83, 5'b01011});
    end
    @(negedge clk);
    or8 = 1; iv8 = 1; op8 = 4'b0111; a8 = 8'h32; b8 = 8'h15; ci8 = 1; bcd8 = 1;
    #1 check("b2b_in_ready", ir8, 1);
    @(posedge clk); #1 iv8 = 0; or8 = 0;
    check("b2b_out_valid_drop", ov8, 0);
    wait_out8("b2b");
    check("b2b_result", res8, 8'h17);
    check("b2b_co", co8, 1);
    @(negedge clk) or8 = 1;
    @(posedge clk); #1 or8 = 0;

    // Reset while running aborts the op.
    @(negedge clk);
    op8 = 4'b0001; a8 = 8'h81; ci8 = 1; bcd8 = 0; iv8 = 1;
    @(posedge clk); #1 iv8 = 0;
    @(negedge clk) rst_n = 0;
    #1;
    check("abort_out_valid", ov8, 0);
    check("abort_in_ready", ir8, 1);
    check("abort_outputs", {res8, co8, v8, z8, n8, hc8}, 0);
    @(negedge clk) rst_n = 1;
    run8("after_abort", 4'b0011, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 5'b01011);

    run16("w16_bcd_9999_0001", 4'b0011, 16'h9999, 16'h0001, 1'b0, 1'b1, 16'h0000, 5'b10101);
    run16("w16_sub_bcd_1000_1", 4'b0111, 16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0999, 5'b10000);

    for (int i = 0; i < 150; i++) begin
      rop = ops[$urandom_range(0, 9)];
      rbcd = 1'($urandom_range(0, 1));
      rci = 1'($urandom_range(0, 1));
      if (rbcd) begin
        ra = rand_bcd(2);
        rb = rand_bcd(2);
      end else begin
        ra = $urandom & 32'hFF;
        rb = $urandom & 32'hFF;
      end
      e = model(8, rop, ra, rb, rci, rbcd);
      run8("rnd8", rop, ra[7:0], rb[7:0], rci, rbcd, e[7:0], e[36:32]);
    end

    for (int i = 0; i < 60; i++) begin
      rop = ops[$urandom_range(0, 9)];
      rbcd = 1'($urandom_range(0, 1));
      rci = 1'($urandom_range(0, 1));
      if (rbcd) begin
        ra = rand_bcd(4);
        rb = rand_bcd(4);
      end else begin
        ra = $urandom & 32'hFFFF;
        rb = $urandom & 32'hFFFF;
      end
      e = model(16, rop, ra, rb, rci, rbcd);
      run16("rnd16", rop, ra[15:0], rb[15:0], rci, rbcd, e[15:0], e[36:32]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
